// File: rtl/vga_timing_mixer_if.sv
// vga_timing_mixer_if
// Bundles the raster/pixel side of the VGA mixer with the sprite replies it collects.
//   master modport (mixer): receives layer_rgb, layer_data, bg_rgb;
//                           drives hcount, vcount, pix_tick, hsync, vsync,
//                           video_on, red, green, blue, frame_start.
//   slave modport (sprite renderers / pins): the mirror image.
interface vga_timing_mixer_if #(
    parameter int N_LAYERS = 4
);
    logic [8*N_LAYERS-1:0] layer_rgb;
    logic [N_LAYERS-1:0]   layer_data;
    logic [7:0]            bg_rgb;
    logic [9:0]            hcount;
    logic [9:0]            vcount;
    logic                  pix_tick;
    logic                  hsync;
    logic                  vsync;
    logic                  video_on;
    logic [2:0]            red;
    logic [2:0]            green;
    logic [1:0]            blue;
    logic                  frame_start;

    modport master (
        input  layer_rgb, layer_data, bg_rgb,
        output hcount, vcount, pix_tick, hsync, vsync, video_on,
               red, green, blue, frame_start
    );

    modport slave (
        output layer_rgb, layer_data, bg_rgb,
        input  hcount, vcount, pix_tick, hsync, vsync, video_on,
               red, green, blue, frame_start
    );
endinterface

// File: rtl/vga_timing_mixer.sv
// vga_timing_mixer
// Raster counter source and pixel sink for the sprite renderers. A clock
// divider produces one pixel tick every CLK_DIV clocks; on each tick the
// current (pre-increment) raster position and the sprite replies are turned
// into registered sync, video_on and 3-3-2 RGB, then hcount/vcount advance.
// Ports:
//   clock, reset      system clock, asynchronous active-high reset
//   vga (master)      layer_rgb/layer_data/bg_rgb in; hcount, vcount,
//                     pix_tick, hsync, vsync, video_on, red, green, blue,
//                     frame_start out
// Optional build macro VGA_MIXER_BORDER_EN: forces the outermost visible
// rows/columns to white for monitor alignment.
module vga_timing_mixer #(
    parameter int CLK_DIV   = 2,
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int N_LAYERS  = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    vga_timing_mixer_if.master   vga
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] divider;
    logic             tick;
    logic             visible;
    logic             h_wrap;
    logic [7:0]       mix_rgb;
    logic [7:0]       pix_rgb;

    assign tick    = (divider == DIV_LAST);
    assign visible = (vga.hcount < H_VIS) && (vga.vcount < V_VIS);
    assign h_wrap  = (vga.hcount == H_LAST);

    // Walk from the lowest priority layer up so the lowest opaque index wins.
    always_comb begin
        mix_rgb = vga.bg_rgb;
        for (int i = N_LAYERS - 1; i >= 0; i--) begin
            if (vga.layer_data[i]) begin
                mix_rgb = vga.layer_rgb[8*i +: 8];
            end
        end
`ifdef VGA_MIXER_BORDER_EN
        if (vga.hcount == 10'd0 || vga.hcount == H_VIS - 10'd1 ||
            vga.vcount == 10'd0 || vga.vcount == V_VIS - 10'd1) begin
            mix_rgb = 8'hFF;
        end
`endif
        pix_rgb = visible ? mix_rgb : 8'h00;
    end

    // Sync, video_on and colour are all loaded on the same tick from the same
    // raster position, so they can never skew relative to each other.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            divider         <= '0;
            vga.hcount      <= 10'd0;
            vga.vcount      <= 10'd0;
            vga.pix_tick    <= 1'b0;
            vga.hsync       <= 1'b1;
            vga.vsync       <= 1'b1;
            vga.video_on    <= 1'b0;
            vga.red         <= 3'd0;
            vga.green       <= 3'd0;
            vga.blue        <= 2'd0;
            vga.frame_start <= 1'b0;
        end else begin
            vga.pix_tick    <= tick;
            vga.frame_start <= tick && h_wrap && (vga.vcount == V_LAST);
            if (tick) begin
                divider      <= '0;
                vga.hsync    <= !((vga.hcount >= HS_START) && (vga.hcount < HS_END));
                vga.vsync    <= !((vga.vcount >= VS_START) && (vga.vcount < VS_END));
                vga.video_on <= visible;
                vga.red      <= pix_rgb[7:5];
                vga.green    <= pix_rgb[4:2];
                vga.blue     <= pix_rgb[1:0];
                if (h_wrap) begin
                    vga.hcount <= 10'd0;
                    vga.vcount <= (vga.vcount == V_LAST) ? 10'd0 : vga.vcount + 10'd1;
                end else begin
                    vga.hcount <= vga.hcount + 10'd1;
                end
            end else begin
                divider <= divider + DIV_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_vga_timing_mixer.sv
// Testbench for vga_timing_mixer: a full-size 640x480 instance for line,
// mixing and blanking behaviour, and a tiny-geometry instance so whole
// frames (vsync, frame_start) fit in a short run. A raster model computes
// every output from the pixel index alone and is compared on every cycle.
module tb_vga_timing_mixer;
    localparam int CLK_DIV = 2;
    localparam int NL      = 4;

    typedef struct {
        int hv, hf, hs, hb, vv, vf, vs, vb;
    } geom_t;

    geom_t g_full  = '{640, 16, 96, 48, 480, 10, 2, 33};
    geom_t g_small = '{16, 4, 6, 6, 12, 2, 2, 3};

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] layer_rgb  = '0;
    logic [3:0]  layer_data = '0;
    logic [7:0]  bg_rgb     = '0;

    int n_checks = 0;
    int n_fails  = 0;

    // Model state: clocks since reset release, ticks taken, inputs at last tick.
    int          edges = 0;
    int          n     = 0;
    logic [31:0] s_rgb  = '0;
    logic [3:0]  s_data = '0;
    logic [7:0]  s_bg   = '0;

    always #5 clock = ~clock;

    vga_timing_mixer_if #(.N_LAYERS(NL)) if_full ();
    vga_timing_mixer_if #(.N_LAYERS(NL)) if_small ();

    assign if_full.layer_rgb   = layer_rgb;
    assign if_full.layer_data  = layer_data;
    assign if_full.bg_rgb      = bg_rgb;
    assign if_small.layer_rgb  = layer_rgb;
    assign if_small.layer_data = layer_data;
    assign if_small.bg_rgb     = bg_rgb;

    vga_timing_mixer #(.CLK_DIV(CLK_DIV), .N_LAYERS(NL)) dut_full (
        .clock (clock),
        .reset (reset),
        .vga   (if_full)
    );

    vga_timing_mixer #(
        .CLK_DIV(CLK_DIV), .H_VISIBLE(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(6),
        .V_VISIBLE(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .N_LAYERS(NL)
    ) dut_small (
        .clock (clock),
        .reset (reset),
        .vga   (if_small)
    );

    task automatic summary();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
            if (n_fails >= 200) begin
                summary();
                $finish;
            end
        end
    endtask

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            edges = 0;
            n     = 0;
        end else begin
            edges++;
            if (edges % CLK_DIV == 0) begin
                n++;
                s_rgb  = layer_rgb;
                s_data = layer_data;
                s_bg   = bg_rgb;
            end
        end
    end

    function automatic logic [7:0] mix_model();
        for (int i = 0; i < NL; i++)
            if (s_data[i]) return s_rgb[8*i +: 8];
        return s_bg;
    endfunction

    task automatic compare(input geom_t g, input string tag,
                           input logic [9:0] hc, input logic [9:0] vc,
                           input logic pt, input logic hs, input logic vs,
                           input logic von, input logic fs, input logic [7:0] rgb);
        int htot, vtot, p, ph, pv;
        logic vis, e_hs, e_vs, e_tick;
        logic [7:0] e_rgb;
        htot   = g.hv + g.hf + g.hs + g.hb;
        vtot   = g.vv + g.vf + g.vs + g.vb;
        e_tick = (edges > 0) && (edges % CLK_DIV == 0);
        e_hs = 1'b1; e_vs = 1'b1; vis = 1'b0; e_rgb = 8'h00;
        if (n > 0) begin
            p  = n - 1;
            ph = p % htot;
            pv = (p / htot) % vtot;
            vis  = (ph < g.hv) && (pv < g.vv);
            e_hs = !(ph >= g.hv + g.hf && ph < g.hv + g.hf + g.hs);
            e_vs = !(pv >= g.vv + g.vf && pv < g.vv + g.vf + g.vs);
            e_rgb = vis ? mix_model() : 8'h00;
`ifdef VGA_MIXER_BORDER_EN
            if (vis && (ph == 0 || ph == g.hv - 1 || pv == 0 || pv == g.vv - 1)) e_rgb = 8'hFF;
`endif
        end
        chk({tag, ".hcount"},      32'(hc),  32'(n % htot));
        chk({tag, ".vcount"},      32'(vc),  32'((n / htot) % vtot));
        chk({tag, ".pix_tick"},    32'(pt),  32'(e_tick));
        chk({tag, ".hsync"},       32'(hs),  32'(e_hs));
        chk({tag, ".vsync"},       32'(vs),  32'(e_vs));
        chk({tag, ".video_on"},    32'(von), 32'(vis));
        chk({tag, ".rgb"},         32'(rgb), 32'(e_rgb));
        chk({tag, ".frame_start"}, 32'(fs),  32'(e_tick && (n % (htot * vtot) == 0)));
    endtask

    always @(negedge clock) begin
        compare(g_full, "full", if_full.hcount, if_full.vcount, if_full.pix_tick,
                if_full.hsync, if_full.vsync, if_full.video_on, if_full.frame_start,
                {if_full.red, if_full.green, if_full.blue});
        compare(g_small, "small", if_small.hcount, if_small.vcount, if_small.pix_tick,
                if_small.hsync, if_small.vsync, if_small.video_on, if_small.frame_start,
                {if_small.red, if_small.green, if_small.blue});
    end

    // Frame-level monitors on the small raster.
    int fs_small_cnt = 0;
    int fs_full_cnt  = 0;
    bit seen_vs = 0;
    bit seen_fs = 0;
    always @(negedge clock) begin
        if (!reset) begin
            if (if_full.frame_start === 1'b1) fs_full_cnt++;
            if (if_small.frame_start === 1'b1) begin
                fs_small_cnt++;
                if (!seen_fs) begin
                    seen_fs = 1;
                    chk("first_frame_start_clock", 32'(edges), 32'd1216);
                    chk("frame_wrap_hcount", 32'(if_small.hcount), 32'd0);
                    chk("frame_wrap_vcount", 32'(if_small.vcount), 32'd0);
                end
            end
            if (!seen_vs && if_small.vsync === 1'b0) begin
                seen_vs = 1;
                chk("first_vsync_low_line", 32'(if_small.vcount), 32'd14);
            end
        end
    end

    task automatic wait_n(input int target);
        int budget = 0;
        while (n != target && budget < 20000) begin
            @(negedge clock);
            budget++;
        end
        if (n != target) chk("wait_tick_timeout", 32'(n), 32'(target));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got timeout expected finish");
        summary();
        $fatal(1);
    end

    initial begin
        int hs_low, von_high, first_low;
        repeat (3) @(negedge clock);
        chk("reset_hcount", 32'(if_full.hcount), 32'd0);
        chk("reset_hsync",  32'(if_full.hsync),  32'd1);
        chk("reset_rgb",    32'({if_full.red, if_full.green, if_full.blue}), 32'd0);

        reset = 1'b0;
        hs_low = 0; von_high = 0; first_low = -1;
        for (int i = 1; i <= 1600; i++) begin
            @(negedge clock);
            if (i == 1) chk("release_pix_tick_1", 32'(if_full.pix_tick), 32'd0);
            if (i == 2) begin
                chk("release_pix_tick_2", 32'(if_full.pix_tick), 32'd1);
                chk("release_hcount",     32'(if_full.hcount),   32'd1);
            end
            if (i % 2 == 0) begin
                if (if_full.hsync === 1'b0) begin
                    hs_low++;
                    if (first_low < 0) first_low = int'(if_full.hcount) - 1;
                end
                if (if_full.video_on === 1'b1) von_high++;
            end
        end
        chk("line_hsync_low_ticks", 32'(hs_low), 32'd96);
        chk("line_first_hsync_px",  32'(first_low), 32'd656);
        chk("line_video_on_ticks",  32'(von_high), 32'd640);

        // Priority mixing at visible pixel (100,1).
        wait_n(900);
        layer_data = 4'b0110;
        layer_rgb  = {8'h00, 8'h1C, 8'hE0, 8'h00};
        wait_n(901);
        chk("mix_red",   32'(if_full.red),   32'd7);
        chk("mix_green", 32'(if_full.green), 32'd0);
        chk("mix_blue",  32'(if_full.blue),  32'd0);
        layer_data = 4'b0000;
        bg_rgb     = 8'h03;
        wait_n(902);
        chk("bg_blue", 32'(if_full.blue), 32'd3);
        chk("bg_rg",   32'({if_full.red, if_full.green}), 32'd0);

        // Blanking at pixel (700,1).
        wait_n(1500);
        layer_data = 4'hF;
        layer_rgb  = 32'hFFFF_FFFF;
        wait_n(1501);
        chk("blank_rgb", 32'({if_full.red, if_full.green, if_full.blue}), 32'd0);
        chk("blank_video_on", 32'(if_full.video_on), 32'd0);

        // Reset at (300,2).
        wait_n(1900);
        chk("pre_reset_hcount", 32'(if_full.hcount), 32'd300);
        chk("pre_reset_vcount", 32'(if_full.vcount), 32'd2);
        chk("small_frames_before_reset", 32'(fs_small_cnt), 32'd3);
        #2 reset = 1'b1;
        #1;
        chk("midreset_hcount",   32'(if_full.hcount),   32'd0);
        chk("midreset_vcount",   32'(if_full.vcount),   32'd0);
        chk("midreset_syncs",    32'({if_full.hsync, if_full.vsync}), 32'd3);
        chk("midreset_video_on", 32'(if_full.video_on), 32'd0);
        chk("midreset_rgb",      32'({if_full.red, if_full.green, if_full.blue}), 32'd0);
        chk("midreset_tick_fs",  32'({if_full.pix_tick, if_full.frame_start}), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("rerelease_pix_tick_1", 32'(if_full.pix_tick), 32'd0);
        @(negedge clock);
        chk("rerelease_pix_tick_2", 32'(if_full.pix_tick), 32'd1);
        chk("rerelease_hcount",     32'(if_full.hcount),   32'd1);
        chk("rerelease_frame_start", 32'(if_small.frame_start), 32'd0);

`ifdef VGA_MIXER_BORDER_EN
        layer_data = 4'b0001;
        layer_rgb  = 32'h0000_0012;
        wait_n(8000);
        wait_n(8001);
        chk("border_px_0_10", 32'({if_full.red, if_full.green, if_full.blue}), 32'hFF);
`endif

        repeat (4) @(negedge clock);
        chk("full_no_frame_start", 32'(fs_full_cnt), 32'd0);
        summary();
        $finish;
    end
endmodule

// File: doc/vga_timing_mixer.md
Name: vga_timing_mixer

Overview:
- Generates the hcount/vcount raster and VGA hsync/vsync that every sprite block (enemies, player, road) consumes.
- Collects those sprites' red/green/blue/data replies and priority-muxes them into the single registered 8-bit RGB (3-3-2) pixel driven to the VGA pins.
- Top-level display endpoint: the counter source and pixel sink for all sprite renderers.

Parameters:
- CLK_DIV, 2, clock cycles per pixel; must be >= 2 so registered sprite replies settle before sampling.
- H_VISIBLE, 640, visible pixels per line.
- H_FRONT, 16, horizontal front porch (pixels).
- H_SYNC, 96, hsync pulse width (pixels).
- H_BACK, 48, horizontal back porch (pixels).
- V_VISIBLE, 480, visible lines.
- V_FRONT, 10, vertical front porch (lines).
- V_SYNC, 2, vsync pulse width (lines).
- V_BACK, 33, vertical back porch (lines).
- N_LAYERS, 4, number of sprite layers; layer 0 has highest priority.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- layer_rgb  in  8*N_LAYERS  per-layer {red[2:0],green[2:0],blue[1:0]}; layer i occupies bits [8i+7:8i].
- layer_data  in  N_LAYERS  per-layer opaque flag (sprite "data" output).
- bg_rgb  in  8  background colour when no layer is opaque.
- hcount  out  10  current pixel column, 0..H_TOTAL-1.
- vcount  out  10  current line, 0..V_TOTAL-1.
- pix_tick  out  1  one-clock strobe; the cycle on which counters advance.
- hsync  out  1  active-low horizontal sync, registered.
- vsync  out  1  active-low vertical sync, registered.
- video_on  out  1  high while the driven pixel is in the visible area.
- red  out  3  pixel red.
- green  out  3  pixel green.
- blue  out  2  pixel blue.
- frame_start  out  1  one-clock pulse when the raster wraps to (0,0).

Behaviour:
- H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800). V_TOTAL = V_VISIBLE+V_FRONT+V_SYNC+V_BACK (525).
- Reset values (asynchronous): divider=0, hcount=0, vcount=0, pix_tick=0, hsync=1, vsync=1, video_on=0, red/green/blue=0, frame_start=0.
- Divider: counts 0..CLK_DIV-1 and wraps. The combinational tick is asserted when divider==CLK_DIV-1. pix_tick is that tick registered (reset 0).
- On a tick edge, the output stage samples the current (pre-increment) hcount/vcount and the layer inputs, then the counters advance.
- Counter advance: hcount wraps at H_TOTAL-1 to 0. On the hcount wrap, vcount increments; vcount wraps at V_TOTAL-1 to 0. Arithmetic is 10-bit; no other wrap.
- visible = hcount<H_VISIBLE && vcount<V_VISIBLE.
- hsync <= 0 iff H_VISIBLE+H_FRONT <= hcount < H_VISIBLE+H_FRONT+H_SYNC, else 1.
- vsync <= 0 iff V_VISIBLE+V_FRONT <= vcount < V_VISIBLE+V_FRONT+V_SYNC, else 1.
- Colour selection:
  - If !visible, rgb <= 0.
  - Otherwise rgb <= layer_rgb of the lowest index i with layer_data[i]==1.
  - If no layer is opaque, rgb <= bg_rgb.
- video_on <= visible.
- Latency: sync, video_on and rgb all describe the same pixel and are valid one tick after that pixel's hcount is presented. Sync and colour are never skewed relative to each other.
- frame_start: high for exactly one clock, on the cycle after the tick edge where hcount==H_TOTAL-1 and vcount==V_TOTAL-1. Low otherwise.
- Between ticks: all outputs hold and layer inputs are ignored.
- Reset mid-frame: everything returns to reset values immediately. On release the raster restarts at (0,0) and the first tick occurs CLK_DIV clocks after release. No frame_start is generated by the reset itself.

Optional Feature:
- Macro: VGA_MIXER_BORDER_EN.
- When defined: visible pixels with hcount==0, hcount==H_VISIBLE-1, vcount==0 or vcount==V_VISIBLE-1 are forced to rgb 8'hFF, overriding all layers and background. Used for monitor alignment.
- When undefined: no override logic is generated; behaviour is exactly as in Behaviour.

Test Plan:
- Reset, then release. Expect: hcount/vcount=0, hsync=vsync=1, rgb=0; first pix_tick 2 clocks after release (CLK_DIV=2); hcount=1 after that tick.
- Run one line. Expect: hsync low for exactly 96 ticks, first low sample reflecting hcount=656; video_on high for 640 ticks, then low.
- Run one full frame. Expect: vsync low during lines 490..491; frame_start pulses once per 800*525 ticks, on the wrap to (0,0).
- Priority mixing: drive layer_data=4'b0110, layer1 rgb 8'hE0, layer2 rgb 8'h1C at visible pixel (100,50). Expect red=7, green=0, blue=0. With layer_data=0 and bg_rgb=8'h03, expect blue=3, red=green=0.
- Blanking: drive layer_data=4'hF at hcount=700. Expect rgb=0 and video_on=0.
- Assert reset at (300,200). Expect immediate return to reset values; restart at (0,0); no spurious frame_start. With VGA_MIXER_BORDER_EN defined, pixel (0,10) outputs 8'hFF regardless of layers.
